// File: rtl/cmd_sequencer.sv
// cmd_sequencer: queues opcode/data commands and issues them one at a time
// to a CommMaster, waiting for the frame-sent and response handshakes.
// Each transaction ends with a one-cycle done pulse, qualified by an
// acknowledge error flag and a response-timeout flag.
module cmd_sequencer #(
    parameter int         DEPTH   = 4,
    parameter int         TMO_CYC = 1000000,
    parameter logic [7:0] POS_ACK = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [7:0]  push_cmd,
    input  logic [15:0] push_data,
    output logic        full,
    output logic        empty,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        snd_cmd,
    input  logic        frm_snt,
    input  logic        resp_rdy,
    input  logic [7:0]  resp,
    output logic        clr_resp_rdy,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rsp_val,
    output logic        ack_err,
    output logic        tmo_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TMO_CYC + 1);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [TW-1:0] TMR_ONE  = TW'(1);
    localparam logic [TW-1:0] TMR_ZERO = TW'(0);
    localparam logic [TW-1:0] TMR_LAST = TW'(TMO_CYC - 1);
    localparam logic [7:0]    REQ_BATT = 8'h01;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND      = 3'd1,
        ST_WAIT_SNT  = 3'd2,
        ST_WAIT_RESP = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    state_t          state_r;
    state_t          state_next_s;

    logic [7:0]      cmd_mem_r  [DEPTH];
    logic [15:0]     data_mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic [TW-1:0]   timer_r;

    logic            wr_en_s;
    logic            pop_s;
    logic            capture_s;
    logic            timeout_s;
    logic            timer_clr_s;

    logic [7:0]      cmd_r;
    logic [15:0]     data_r;
    logic            snd_cmd_r;
    logic            clr_resp_rdy_r;
    logic            busy_r;
    logic            done_r;
    logic [7:0]      rsp_val_r;
    logic            ack_err_r;
    logic            tmo_err_r;

    // A push is dropped whenever the queue is full, even if a pop frees a slot this cycle.
    assign wr_en_s = push && (count_r != CNT_FULL);

    assign full         = (count_r == CNT_FULL);
    assign empty        = (count_r == CNT_ZERO);
    assign cmd          = cmd_r;
    assign data         = data_r;
    assign snd_cmd      = snd_cmd_r;
    assign clr_resp_rdy = clr_resp_rdy_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign rsp_val      = rsp_val_r;
    assign ack_err      = ack_err_r;
    assign tmo_err      = tmo_err_r;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode plus the per-cycle pop/capture/timeout strobes.
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        capture_s    = 1'b0;
        timeout_s    = 1'b0;
        timer_clr_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (count_r != CNT_ZERO) begin
                    pop_s        = 1'b1;
                    state_next_s = ST_SEND;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                state_next_s = ST_WAIT_SNT;
            end
            ST_WAIT_SNT: begin
                if (frm_snt) begin
                    timer_clr_s  = 1'b1;
                    state_next_s = ST_WAIT_RESP;
                end else begin
                    state_next_s = ST_WAIT_SNT;
                end
            end
            ST_WAIT_RESP: begin
                // A response arriving on the last allowed cycle still counts.
                if (resp_rdy) begin
                    capture_s    = 1'b1;
                    state_next_s = ST_DONE;
                end else if (timer_r == TMR_LAST) begin
                    timeout_s    = 1'b1;
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_WAIT_RESP;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Circular command queue: storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= CNT_ZERO;
            for (int i = 0; i < DEPTH; i++) begin
                cmd_mem_r[i]  <= 8'h00;
                data_mem_r[i] <= 16'h0000;
            end
        end else begin
            if (wr_en_s) begin
                cmd_mem_r[wr_ptr_r]  <= push_cmd;
                data_mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r             <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({wr_en_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Response timer: zeroed on entering WAIT_RESP, counts while waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_r <= TMR_ZERO;
        end else if (timer_clr_s) begin
            timer_r <= TMR_ZERO;
        end else if (state_r == ST_WAIT_RESP) begin
            timer_r <= timer_r + TMR_ONE;
        end else begin
            timer_r <= timer_r;
        end
    end

    // Registered outputs toward CommMaster and the transaction status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_r          <= 8'h00;
            data_r         <= 16'h0000;
            snd_cmd_r      <= 1'b0;
            clr_resp_rdy_r <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            rsp_val_r      <= 8'h00;
            ack_err_r      <= 1'b0;
            tmo_err_r      <= 1'b0;
        end else begin
            if (pop_s) begin
                cmd_r  <= cmd_mem_r[rd_ptr_r];
                data_r <= data_mem_r[rd_ptr_r];
            end
            if (capture_s) begin
                rsp_val_r <= resp;
            end
            snd_cmd_r      <= (state_next_s == ST_SEND);
            busy_r         <= (state_next_s != ST_IDLE);
            done_r         <= (state_next_s == ST_DONE);
            clr_resp_rdy_r <= capture_s;
            // Battery requests return a data byte, not an acknowledge code.
            ack_err_r      <= capture_s && (cmd_r != REQ_BATT) && (resp != POS_ACK);
            tmo_err_r      <= timeout_s;
        end
    end

endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed testbench for cmd_sequencer (DEPTH=4, TMO_CYC=100).
// The bench plays the CommMaster role by hand inside each scenario task.
module tb_cmd_sequencer;

    logic        clk;
    logic        rst_n;
    logic        push;
    logic [7:0]  push_cmd;
    logic [15:0] push_data;
    logic        full;
    logic        empty;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        snd_cmd;
    logic        frm_snt;
    logic        resp_rdy;
    logic [7:0]  resp;
    logic        clr_resp_rdy;
    logic        busy;
    logic        done;
    logic [7:0]  rsp_val;
    logic        ack_err;
    logic        tmo_err;

    int          n_pass;
    int          n_total;
    logic [7:0]  last_rsp;

    localparam logic [39:0] RESET_VEC = {1'b0, 1'b1, 8'h00, 16'h0000, 1'b0, 1'b0,
                                         1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

    cmd_sequencer #(
        .DEPTH   (4),
        .TMO_CYC (100),
        .POS_ACK (8'hA5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (push),
        .push_cmd     (push_cmd),
        .push_data    (push_data),
        .full         (full),
        .empty        (empty),
        .cmd          (cmd),
        .data         (data),
        .snd_cmd      (snd_cmd),
        .frm_snt      (frm_snt),
        .resp_rdy     (resp_rdy),
        .resp         (resp),
        .clr_resp_rdy (clr_resp_rdy),
        .busy         (busy),
        .done         (done),
        .rsp_val      (rsp_val),
        .ack_err      (ack_err),
        .tmo_err      (tmo_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Enqueue one entry; called and returns on a falling edge.
    task automatic push_one(input logic [7:0] c, input logic [15:0] d);
        push      = 1'b1;
        push_cmd  = c;
        push_data = d;
        @(negedge clk);
        push      = 1'b0;
    endtask

    // Wait (bounded) for the send strobe and check the presented command.
    task automatic expect_send(input logic [7:0] c, input logic [15:0] d);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (snd_cmd === 1'b1) seen = 1'b1;
        end
        n_total++;
        if (!seen) $display("FAIL send_wait cmd %h: snd_cmd not seen within 20 cycles", c);
        else n_pass++;
        n_total++;
        if ({cmd, data, busy} !== {c, d, 1'b1})
            $display("FAIL send_fields got cmd=%h data=%h busy=%b want cmd=%h data=%h busy=1",
                     cmd, data, busy, c, d);
        else n_pass++;
    endtask

    // Frame-sent then response handshake; ends on the cycle done is expected.
    task automatic finish_txn(input logic [7:0] r, input logic exp_ack);
        frm_snt = 1'b1;
        @(negedge clk);
        n_total++;
        if (snd_cmd !== 1'b0) $display("FAIL snd_one_cycle got snd_cmd=%b want 0", snd_cmd);
        else n_pass++;
        @(negedge clk);
        frm_snt  = 1'b0;
        resp_rdy = 1'b1;
        resp     = r;
        @(negedge clk);
        n_total++;
        if ({done, clr_resp_rdy, rsp_val, ack_err, tmo_err} !== {1'b1, 1'b1, r, exp_ack, 1'b0})
            $display("FAIL txn_done got done=%b clr=%b rsp_val=%h ack_err=%b tmo_err=%b want 1 1 %h %b 0",
                     done, clr_resp_rdy, rsp_val, ack_err, tmo_err, r, exp_ack);
        else n_pass++;
        resp_rdy = 1'b0;
        last_rsp = r;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_total++;
        if ({full, empty, cmd, data, snd_cmd, clr_resp_rdy, busy, done, rsp_val, ack_err, tmo_err} !== RESET_VEC)
            $display("FAIL reset_values got %h want %h",
                     {full, empty, cmd, data, snd_cmd, clr_resp_rdy, busy, done, rsp_val, ack_err, tmo_err},
                     RESET_VEC);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_req_batt();
        push_one(8'h01, 16'h0000);
        n_total++;
        if (empty !== 1'b0) $display("FAIL batt_not_empty got empty=%b want 0", empty);
        else n_pass++;
        expect_send(8'h01, 16'h0000);
        finish_txn(8'hC0, 1'b0);
        @(negedge clk);
        n_total++;
        if ({done, busy, empty, rsp_val} !== {1'b0, 1'b0, 1'b1, 8'hC0})
            $display("FAIL batt_after got done=%b busy=%b empty=%b rsp_val=%h want 0 0 1 c0",
                     done, busy, empty, rsp_val);
        else n_pass++;
    endtask

    task automatic test_ack_check();
        push_one(8'h05, 16'h0123);
        expect_send(8'h05, 16'h0123);
        finish_txn(8'hA5, 1'b0);
        push_one(8'h05, 16'h0123);
        expect_send(8'h05, 16'h0123);
        finish_txn(8'hFF, 1'b1);
        for (int i = 0; i < 4; i++) @(negedge clk);
        n_total++;
        if ({cmd, data, ack_err, done} !== {8'h05, 16'h0123, 1'b0, 1'b0})
            $display("FAIL ack_hold got cmd=%h data=%h ack_err=%b done=%b want 05 0123 0 0",
                     cmd, data, ack_err, done);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit extra;
        push_one(8'h10, 16'h1000);
        expect_send(8'h10, 16'h1000);
        for (int i = 0; i < 5; i++) begin
            push_one(8'(8'h11 + i), 16'(16'h1100 + i));
            if (i == 2) begin
                n_total++;
                if (full !== 1'b0) $display("FAIL b2b_not_full_3 got full=%b want 0", full);
                else n_pass++;
            end else if (i >= 3) begin
                n_total++;
                if (full !== 1'b1) $display("FAIL b2b_full_%0d got full=%b want 1", i + 1, full);
                else n_pass++;
            end
        end
        finish_txn(8'hA5, 1'b0);
        for (int i = 0; i < 4; i++) begin
            expect_send(8'(8'h11 + i), 16'(16'h1100 + i));
            finish_txn(8'hA5, 1'b0);
        end
        extra = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (snd_cmd === 1'b1 || done === 1'b1) extra = 1'b1;
        end
        n_total++;
        if ({extra, empty} !== {1'b0, 1'b1})
            $display("FAIL b2b_dropped got extra_activity=%b empty=%b want 0 1", extra, empty);
        else n_pass++;
    endtask

    task automatic test_push_pop_same();
        bit extra;
        push_one(8'h20, 16'h2000);
        expect_send(8'h20, 16'h2000);
        push_one(8'h21, 16'h2100);
        push_one(8'h22, 16'h2200);
        push_one(8'h23, 16'h2300);
        finish_txn(8'hA5, 1'b0);
        @(negedge clk);
        push      = 1'b1;
        push_cmd  = 8'h24;
        push_data = 16'h2400;
        @(negedge clk);
        push      = 1'b0;
        n_total++;
        if ({snd_cmd, cmd, full, empty} !== {1'b1, 8'h21, 1'b0, 1'b0})
            $display("FAIL pp_accept got snd=%b cmd=%h full=%b empty=%b want 1 21 0 0",
                     snd_cmd, cmd, full, empty);
        else n_pass++;
        push_one(8'h25, 16'h2500);
        n_total++;
        if (full !== 1'b1) $display("FAIL pp_full got full=%b want 1", full);
        else n_pass++;
        finish_txn(8'hA5, 1'b0);
        @(negedge clk);
        push      = 1'b1;
        push_cmd  = 8'h26;
        push_data = 16'h2600;
        @(negedge clk);
        push      = 1'b0;
        n_total++;
        if ({snd_cmd, cmd, full} !== {1'b1, 8'h22, 1'b0})
            $display("FAIL pp_drop got snd=%b cmd=%h full=%b want 1 22 0", snd_cmd, cmd, full);
        else n_pass++;
        finish_txn(8'hA5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            expect_send(8'(8'h23 + i), 16'(16'h2300 + 16'(i) * 16'h0100));
            finish_txn(8'hA5, 1'b0);
        end
        extra = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (snd_cmd === 1'b1) extra = 1'b1;
        end
        n_total++;
        if ({extra, empty} !== {1'b0, 1'b1})
            $display("FAIL pp_drained got extra_send=%b empty=%b want 0 1", extra, empty);
        else n_pass++;
    endtask

    task automatic test_timeout();
        bit early;
        push_one(8'h30, 16'h3000);
        expect_send(8'h30, 16'h3000);
        push_one(8'h31, 16'h3100);
        frm_snt = 1'b1;
        @(negedge clk);
        frm_snt = 1'b0;
        early   = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k < 100 && done === 1'b1) early = 1'b1;
        end
        n_total++;
        if (early !== 1'b0) $display("FAIL tmo_early got early_done=1 want 0");
        else n_pass++;
        n_total++;
        if ({done, tmo_err, ack_err, clr_resp_rdy, rsp_val} !== {1'b1, 1'b1, 1'b0, 1'b0, last_rsp})
            $display("FAIL tmo_done got done=%b tmo=%b ack=%b clr=%b rsp_val=%h want 1 1 0 0 %h",
                     done, tmo_err, ack_err, clr_resp_rdy, rsp_val, last_rsp);
        else n_pass++;
        expect_send(8'h31, 16'h3100);
        finish_txn(8'h5A, 1'b1);
    endtask

    task automatic test_timeout_boundary();
        bit early;
        push_one(8'h32, 16'h3200);
        expect_send(8'h32, 16'h3200);
        frm_snt = 1'b1;
        @(negedge clk);
        @(negedge clk);
        frm_snt = 1'b0;
        early   = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k < 100 && done === 1'b1) early = 1'b1;
            if (k == 99) begin
                resp_rdy = 1'b1;
                resp     = 8'hA5;
            end
        end
        resp_rdy = 1'b0;
        n_total++;
        if (early !== 1'b0) $display("FAIL tmo_edge_early got early_done=1 want 0");
        else n_pass++;
        n_total++;
        if ({done, tmo_err, ack_err, clr_resp_rdy, rsp_val} !== {1'b1, 1'b0, 1'b0, 1'b1, 8'hA5})
            $display("FAIL tmo_edge_resp got done=%b tmo=%b ack=%b clr=%b rsp_val=%h want 1 0 0 1 a5",
                     done, tmo_err, ack_err, clr_resp_rdy, rsp_val);
        else n_pass++;
        last_rsp = 8'hA5;
    endtask

    task automatic test_reset_mid();
        bit activity;
        push_one(8'h40, 16'h4000);
        expect_send(8'h40, 16'h4000);
        frm_snt = 1'b1;
        @(negedge clk);
        @(negedge clk);
        frm_snt = 1'b0;
        push_one(8'h41, 16'h4100);
        push_one(8'h42, 16'h4200);
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({full, empty, cmd, data, snd_cmd, clr_resp_rdy, busy, done, rsp_val, ack_err, tmo_err} !== RESET_VEC)
            $display("FAIL mid_reset_values got %h want %h",
                     {full, empty, cmd, data, snd_cmd, clr_resp_rdy, busy, done, rsp_val, ack_err, tmo_err},
                     RESET_VEC);
        else n_pass++;
        @(negedge clk);
        rst_n    = 1'b1;
        activity = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1 || snd_cmd === 1'b1 || busy === 1'b1) activity = 1'b1;
        end
        n_total++;
        if ({activity, empty} !== {1'b0, 1'b1})
            $display("FAIL mid_reset_quiet got activity=%b empty=%b want 0 1", activity, empty);
        else n_pass++;
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        last_rsp  = 8'h00;
        rst_n     = 1'b0;
        push      = 1'b0;
        push_cmd  = 8'h00;
        push_data = 16'h0000;
        frm_snt   = 1'b0;
        resp_rdy  = 1'b0;
        resp      = 8'h00;

        test_reset();
        test_req_batt();
        test_ack_check();
        test_back_to_back();
        test_push_pop_same();
        test_timeout();
        test_timeout_boundary();
        test_reset_mid();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cmd_sequencer.md
CMD_SEQUENCER -- requirements
Module: cmd_sequencer

Interface
REQ-001 Parameter: DEPTH, 4, command queue entries (power of 2, 2..16).
REQ-002 Parameter: TMO_CYC, 1000000, max clk cycles from WAIT_RESP entry to resp_rdy (20 ms at 50 MHz).
REQ-003 Parameter: POS_ACK, 8'hA5, expected positive acknowledge byte.
REQ-004 clk  in  1  system clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 push  in  1  enqueue request, one entry per high cycle.
REQ-007 push_cmd  in  8  opcode to enqueue.
REQ-008 push_data  in  16  data word to enqueue.
REQ-009 full  out  1  queue holds DEPTH entries.
REQ-010 empty  out  1  queue holds 0 entries.
REQ-011 cmd  out  8  opcode to CommMaster, registered.
REQ-012 data  out  16  data to CommMaster, registered.
REQ-013 snd_cmd  out  1  one-cycle send strobe to CommMaster.
REQ-014 frm_snt  in  1  CommMaster frame-sent indication.
REQ-015 resp_rdy  in  1  CommMaster response valid (level, held until cleared).
REQ-016 resp  in  8  CommMaster response byte.
REQ-017 clr_resp_rdy  out  1  one-cycle knock-down of resp_rdy.
REQ-018 busy  out  1  transaction in progress (state != IDLE).
REQ-019 done  out  1  one-cycle pulse, transaction finished.
REQ-020 rsp_val  out  8  last captured response byte, held until next capture.
REQ-021 ack_err  out  1  qualifies done: response not POS_ACK on non-REQ_BATT opcode.
REQ-022 tmo_err  out  1  qualifies done: response timeout.

Function
REQ-023 Queue: circular FIFO, rd/wr pointers of log2(DEPTH) bits wrapping DEPTH-1 -> 0, count 0..DEPTH; full/empty decoded from registered count.
REQ-024 push while full: entry dropped, FIFO unchanged, even if a pop occurs the same cycle.
REQ-025 push and pop same cycle, not full: both performed, count unchanged.
REQ-026 FSM states: IDLE, SEND, WAIT_SNT, WAIT_RESP, DONE.
REQ-027 IDLE: if !empty, pop head into cmd/data registers, go SEND next cycle; else stay.
REQ-028 SEND: snd_cmd high exactly one cycle; go WAIT_SNT.
REQ-029 WAIT_SNT: stay until frm_snt high; then clear timer, go WAIT_RESP; resp_rdy ignored here.
REQ-030 WAIT_RESP: timer increments each cycle; on resp_rdy, capture resp into rsp_val, clr_resp_rdy high one cycle, go DONE.
REQ-031 Timeout: timer reaching TMO_CYC-1 without resp_rdy -> go DONE with tmo_err; rsp_val unchanged; resp_rdy on that same cycle wins (normal capture, no timeout).
REQ-032 Ack check: cmd == 8'h01 (REQ_BATT) -> any byte accepted, ack_err 0; other opcodes -> ack_err = (resp != POS_ACK).
REQ-033 DONE: done high one cycle with ack_err/tmo_err valid that cycle only; go IDLE.
REQ-034 Minimum spacing: next IDLE pop occurs cycle after DONE; queue pushes accepted in every state.
REQ-035 Latency: pop to snd_cmd = 1 cycle; resp_rdy to done = 1 cycle.
REQ-036 cmd/data outputs hold values from pop until next pop.

Reset
REQ-037 rst_n low asynchronously: FSM to IDLE, FIFO pointers/count 0, timer 0.
REQ-038 Reset values: full 0, empty 1, cmd 8'h00, data 16'h0000, snd_cmd 0, clr_resp_rdy 0, busy 0, done 0, rsp_val 8'h00, ack_err 0, tmo_err 0.
REQ-039 Reset mid-transaction: in-flight and queued commands discarded; no done pulse issued.

Verification
REQ-040 Push {8'h01,16'h0000}, CommMaster returns 8'hC0 -> one snd_cmd, done with rsp_val 8'hC0, ack_err 0, tmo_err 0.
REQ-041 Push {8'h05,16'h0123}, resp 8'hA5 -> cmd 8'h05, data 16'h0123 at snd_cmd, done, ack_err 0; resp 8'hFF instead -> ack_err 1.
REQ-042 Push 5 commands back-to-back with DEPTH=4, no draining -> full after 4th, 5th dropped, exactly 4 done pulses in push order.
REQ-043 resp_rdy never asserted, TMO_CYC=100 -> done with tmo_err 1 exactly 100 cycles after WAIT_RESP entry, rsp_val unchanged, next queued command proceeds.
REQ-044 Push while FIFO at DEPTH-1 and popping same cycle -> accepted, count unchanged; push while full and popping -> dropped.
REQ-045 rst_n low during WAIT_RESP with 2 entries queued -> all outputs at reset values immediately, empty 1, no done after release.
